uio_cmd_decoder: RTL and testbench

Decodes the HPS user-I/O (UIO) word stream into system-level configuration registers for the top level. Sits between the HPS general-purpose bus front end (strobe/ack generation) and the consumers of configuration: HDMI config, VGA/YPbPr/csync selection, scaler aspect ratio and the reset-request latch. Each UIO transaction is one command word followed by zero or more data words. Outputs update only when a command is complete, so partial transactions never leak.

---
 rtl/uio_cmd_pkg.sv | 33 +++
 rtl/uio_strobe_edge.sv | 35 +++
 rtl/uio_cmd_decoder.sv | 103 ++++++++++
 tb/tb_uio_cmd_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uio_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uio_cmd_pkg
//  Purpose  : Opcodes, FSM state type and data-word counts for the UIO
//             command decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package uio_cmd_pkg;

   localparam logic [7:0] CMD_SET_CFG    = 8'h01;
   localparam logic [7:0] CMD_GET_STATUS = 8'h02;
   localparam logic [7:0] CMD_SET_AR     = 8'h03;
   localparam logic [7:0] CMD_SET_RESET  = 8'h04;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      DRAIN = 2'd2
   } uio_state_e;

   // Unknown opcodes report zero data words so they fall straight to DRAIN.
   function automatic logic [1:0] cmd_data_words(input logic [7:0] opcode);
      case (opcode)
         CMD_SET_CFG:    cmd_data_words = 2'd1;
         CMD_GET_STATUS: cmd_data_words = 2'd0;
         CMD_SET_AR:     cmd_data_words = 2'd2;
         CMD_SET_RESET:  cmd_data_words = 2'd1;
         default:        cmd_data_words = 2'd0;
      endcase
   endfunction

endpackage : uio_cmd_pkg
`default_nettype wire

// File: rtl/uio_strobe_edge.sv
`default_nettype none
// ============================================================================
//  Module   : uio_strobe_edge
//  Purpose  : One-cycle word-accept pulse from the HPS level strobe, gated
//             by the UIO transaction enable.
//  Revision : 1.0 - initial release
// ============================================================================
module uio_strobe_edge (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic io_strobe,
   input  logic io_uio,
   output logic accept
);

   logic r_strobe_d;
   logic r_armed;

   // r_armed stays low while a strobe that was already high at reset release
   // is still held, so that strobe never counts as a fresh edge.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         r_strobe_d <= 1'b0;
         r_armed    <= ~io_strobe;
      end else begin
         r_strobe_d <= io_strobe;
         if (!io_strobe)
            r_armed <= 1'b1;
      end
   end

   assign accept = io_uio & io_strobe & ~r_strobe_d & r_armed;

endmodule : uio_strobe_edge
`default_nettype wire

// File: rtl/uio_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : uio_cmd_decoder
//  Purpose  : Decodes HPS UIO command/data words into configuration registers;
//             outputs change only when a command completes.
//  Revision : 1.0 - initial release
// ============================================================================
module uio_cmd_decoder
   import uio_cmd_pkg::*;
#(
   parameter logic [7:0]  DEF_ARX   = 8'd4,
   parameter logic [7:0]  DEF_ARY   = 8'd3,
   parameter logic [15:0] CFG_RESET = 16'h0000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        io_uio,
   input  logic        io_strobe,
   input  logic [15:0] io_din,
   input  logic [15:0] status,
   output logic [15:0] io_dout,
   output logic        io_wide,
   output logic [15:0] cfg,
   output logic        cfg_ready,
   output logic [7:0]  arx,
   output logic [7:0]  ary,
   output logic        reset_req
);

   uio_state_e r_state;
   logic [1:0] r_idx;
   logic [7:0] r_opcode;
   logic [7:0] r_ar_stage;
   logic       w_accept;
   logic [1:0] w_op_words;
   logic [1:0] w_cur_words;
   logic       w_last_word;

   uio_strobe_edge u_strobe_edge (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .io_strobe (io_strobe),
      .io_uio    (io_uio),
      .accept    (w_accept)
   );

   assign io_wide     = 1'b1;
   assign w_op_words  = cmd_data_words(io_din[7:0]);
   assign w_cur_words = cmd_data_words(r_opcode);
   assign w_last_word = (r_idx == (w_cur_words - 2'd1));

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_idx      <= 2'd0;
         r_opcode   <= 8'd0;
         r_ar_stage <= 8'd0;
         io_dout    <= 16'h0000;
         cfg        <= CFG_RESET;
         cfg_ready  <= 1'b0;
         arx        <= DEF_ARX;
         ary        <= DEF_ARY;
         reset_req  <= 1'b0;
      end else if (!io_uio) begin
         r_state <= IDLE;
         r_idx   <= 2'd0;
      end else if (w_accept) begin
         case (r_state)
            IDLE: begin
               r_opcode <= io_din[7:0];
               r_idx    <= 2'd0;
               if (io_din[7:0] == CMD_GET_STATUS)
                  io_dout <= status;
               r_state <= (w_op_words == 2'd0) ? DRAIN : DATA;
            end
            DATA: begin
               if (r_opcode == CMD_SET_AR && r_idx == 2'd0)
                  r_ar_stage <= io_din[7:0];
               if (w_last_word) begin
                  case (r_opcode)
                     CMD_SET_CFG: begin
                        cfg       <= io_din;
                        cfg_ready <= 1'b1;
                     end
                     CMD_SET_AR: begin
                        arx <= r_ar_stage;
                        ary <= io_din[7:0];
                     end
                     CMD_SET_RESET: reset_req <= io_din[0];
                     default: ;
                  endcase
                  r_state <= DRAIN;
               end else begin
                  r_idx <= r_idx + 2'd1;
               end
            end
            default: r_state <= DRAIN;
         endcase
      end
   end

endmodule : uio_cmd_decoder
`default_nettype wire

// File: tb/tb_uio_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uio_cmd_decoder
//  Purpose  : Directed vector table plus hand sequences for uio_cmd_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uio_cmd_decoder;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        io_uio;
   logic        io_strobe;
   logic [15:0] io_din;
   logic [15:0] status;
   logic [15:0] io_dout;
   logic        io_wide;
   logic [15:0] cfg;
   logic        cfg_ready;
   logic [7:0]  arx;
   logic [7:0]  ary;
   logic        reset_req;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk_sys = ~clk_sys;

   uio_cmd_decoder #(
      .DEF_ARX   (8'd4),
      .DEF_ARY   (8'd3),
      .CFG_RESET (16'h0000)
   ) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .io_uio    (io_uio),
      .io_strobe (io_strobe),
      .io_din    (io_din),
      .status    (status),
      .io_dout   (io_dout),
      .io_wide   (io_wide),
      .cfg       (cfg),
      .cfg_ready (cfg_ready),
      .arx       (arx),
      .ary       (ary),
      .reset_req (reset_req)
   );

   typedef struct {
      int               n;
      logic [2:0][15:0] w;
      logic [15:0]      st;
      logic [15:0]      e_cfg;
      logic             e_rdy;
      logic [7:0]       e_arx;
      logic [7:0]       e_ary;
      logic             e_rr;
      logic [15:0]      e_dout;
   } vec_t;

   vec_t vecs[8];

   function automatic vec_t mk(input int n, input logic [15:0] w0, w1, w2, st,
                               input logic [15:0] e_cfg, input logic e_rdy,
                               input logic [7:0] e_arx, e_ary, input logic e_rr,
                               input logic [15:0] e_dout);
      vec_t v;
      v.n = n; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.st = st;
      v.e_cfg = e_cfg; v.e_rdy = e_rdy; v.e_arx = e_arx; v.e_ary = e_ary;
      v.e_rr = e_rr; v.e_dout = e_dout;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [15:0] e_cfg, input logic e_rdy,
                            input logic [7:0] e_arx, e_ary, input logic e_rr,
                            input logic [15:0] e_dout);
      check({tag, ".cfg"},       cfg,                 e_cfg);
      check({tag, ".cfg_ready"}, {15'd0, cfg_ready},  {15'd0, e_rdy});
      check({tag, ".arx"},       {8'd0, arx},         {8'd0, e_arx});
      check({tag, ".ary"},       {8'd0, ary},         {8'd0, e_ary});
      check({tag, ".reset_req"}, {15'd0, reset_req},  {15'd0, e_rr});
      check({tag, ".io_dout"},   io_dout,             e_dout);
      check({tag, ".io_wide"},   {15'd0, io_wide},    16'd1);
   endtask

   // Word: strobe high for one cycle then low for one cycle; the accept
   // commits on the posedge inside the high phase.
   task automatic send(input logic [15:0] w);
      io_din    = w;
      io_strobe = 1'b1;
      @(negedge clk_sys);
      io_strobe = 1'b0;
      @(negedge clk_sys);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0; io_uio = 1'b0; io_strobe = 1'b0; io_din = '0; status = '0;
      repeat (3) @(negedge clk_sys);
      reset_n = 1'b1;
      @(negedge clk_sys);
      check_all("reset", 16'h0000, 1'b0, 8'd4, 8'd3, 1'b0, 16'h0000);

      vecs[0] = mk(3, 16'h0001, 16'h0064, 16'hFFFF, 16'h0000, 16'h0064, 1, 8'h04, 8'h03, 0, 16'h0000);
      vecs[1] = mk(3, 16'h0003, 16'h0010, 16'h0009, 16'h0000, 16'h0064, 1, 8'h10, 8'h09, 0, 16'h0000);
      vecs[2] = mk(1, 16'h0002, 16'h0000, 16'h0000, 16'hBEEF, 16'h0064, 1, 8'h10, 8'h09, 0, 16'hBEEF);
      vecs[3] = mk(3, 16'h007F, 16'h1111, 16'h2222, 16'hAAAA, 16'h0064, 1, 8'h10, 8'h09, 0, 16'hBEEF);
      vecs[4] = mk(2, 16'h0004, 16'h0001, 16'h0000, 16'hAAAA, 16'h0064, 1, 8'h10, 8'h09, 1, 16'hBEEF);
      vecs[5] = mk(2, 16'h0101, 16'h00A5, 16'h0000, 16'hAAAA, 16'h00A5, 1, 8'h10, 8'h09, 1, 16'hBEEF);
      vecs[6] = mk(2, 16'h0004, 16'h0000, 16'h0000, 16'h5555, 16'h00A5, 1, 8'h10, 8'h09, 0, 16'hBEEF);
      vecs[7] = mk(1, 16'hFF02, 16'h0000, 16'h0000, 16'h1234, 16'h00A5, 1, 8'h10, 8'h09, 0, 16'h1234);

      for (int i = 0; i < 8; i++) begin
         status = vecs[i].st;
         io_uio = 1'b1;
         @(negedge clk_sys);
         for (int k = 0; k < vecs[i].n; k++) send(vecs[i].w[k]);
         check_all($sformatf("vec%0d", i), vecs[i].e_cfg, vecs[i].e_rdy, vecs[i].e_arx,
                   vecs[i].e_ary, vecs[i].e_rr, vecs[i].e_dout);
         io_uio = 1'b0;
         @(negedge clk_sys);
      end

      // Status changes without a command must not reach io_dout.
      status = 16'h9999;
      repeat (3) @(negedge clk_sys);
      check("dout_hold", io_dout, 16'h1234);

      // SET_AR: nothing moves after word1; both commit on word2's accept edge.
      io_uio = 1'b1;
      @(negedge clk_sys);
      send(16'h0003);
      send(16'h0007);
      check("ar_staged_arx", {8'd0, arx}, 16'h0010);
      io_din = 16'h0008; io_strobe = 1'b1;
      #1;
      check("ar_pre_edge_ary", {8'd0, ary}, 16'h0009);
      @(negedge clk_sys);
      check("ar_commit_arx", {8'd0, arx}, 16'h0007);
      check("ar_commit_ary", {8'd0, ary}, 16'h0008);
      io_strobe = 1'b0;
      @(negedge clk_sys);
      io_uio = 1'b0;
      @(negedge clk_sys);

      // Aborted SET_AR, then a fresh one must start from IDLE.
      io_uio = 1'b1;
      @(negedge clk_sys);
      send(16'h0003);
      send(16'h0005);
      io_uio = 1'b0;
      @(negedge clk_sys);
      check("abort_arx", {8'd0, arx}, 16'h0007);
      check("abort_ary", {8'd0, ary}, 16'h0008);
      io_uio = 1'b1;
      @(negedge clk_sys);
      send(16'h0003); send(16'h000C); send(16'h000D);
      check("after_abort_arx", {8'd0, arx}, 16'h000C);
      check("after_abort_ary", {8'd0, ary}, 16'h000D);
      io_uio = 1'b0;
      @(negedge clk_sys);

      // Strobe held high for 10 cycles is one word only.
      io_uio = 1'b1;
      @(negedge clk_sys);
      io_din = 16'h0001; io_strobe = 1'b1;
      repeat (10) @(negedge clk_sys);
      io_strobe = 1'b0;
      @(negedge clk_sys);
      send(16'h0077);
      check("held_strobe_cfg", cfg, 16'h0077);
      io_uio = 1'b0;
      @(negedge clk_sys);

      // io_uio falling in the same cycle as the strobe edge drops the word.
      io_uio = 1'b1;
      @(negedge clk_sys);
      send(16'h0001);
      io_din = 16'h0055; io_strobe = 1'b1; io_uio = 1'b0;
      @(negedge clk_sys);
      io_strobe = 1'b0;
      @(negedge clk_sys);
      check("uio_fall_cfg", cfg, 16'h0077);

      io_uio = 1'b1;
      @(negedge clk_sys);
      send(16'h0004); send(16'h0001);
      check("set_reset_rr", {15'd0, reset_req}, 16'd1);
      io_uio = 1'b0;
      @(negedge clk_sys);

      // Reset in the middle of SET_CFG: back to reset values and IDLE.
      io_uio = 1'b1;
      @(negedge clk_sys);
      send(16'h0001);
      reset_n = 1'b0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      @(negedge clk_sys);
      check_all("mid_reset", 16'h0000, 1'b0, 8'd4, 8'd3, 1'b0, 16'h0000);
      send(16'h0099);
      send(16'h0042);
      check("mid_reset_idle_cfg", cfg, 16'h0000);
      check("mid_reset_idle_rdy", {15'd0, cfg_ready}, 16'd0);
      io_uio = 1'b0;
      @(negedge clk_sys);

      // Strobe already high at reset release is not an edge.
      status = 16'hCAFE; io_din = 16'h0002; io_uio = 1'b1; io_strobe = 1'b1;
      reset_n = 1'b0;
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (3) @(negedge clk_sys);
      check("held_at_reset_dout", io_dout, 16'h0000);
      io_strobe = 1'b0;
      @(negedge clk_sys);
      send(16'h0002);
      check("post_reset_status_dout", io_dout, 16'hCAFE);
      io_uio = 1'b0;
      @(negedge clk_sys);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_uio_cmd_decoder
`default_nettype wire
